// File: rtl/rcn_testmon.sv
// rcn_testmon: ring-bus test monitor. Sits on the 67-bit ring, answers
// requests in a 32-word window at ADDR_BASE with per-channel progress, fail,
// pass and status registers, and forwards every other word one cycle later.
// Optional per-channel watchdog: define RCN_TESTMON_WATCHDOG_EN.
module rcn_testmon #(
   parameter logic [21:0]          ADDR_BASE = 22'h3FFFE0,
   parameter int unsigned          NUM_CH    = 4,
   parameter int unsigned          TIMEOUT_W = 24,
   parameter logic [TIMEOUT_W-1:0] TIMEOUT   = 24'd1000000
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [66:0]            rcn_in,
   output logic [66:0]            rcn_out,
   output logic [32*NUM_CH-1:0]   test_progress,
   output logic [32*NUM_CH-1:0]   test_fail,
   output logic [32*NUM_CH-1:0]   test_pass,
   output logic [NUM_CH-1:0]      test_timeout
);

   // Reject parameter values the register map and watchdog cannot represent.
   if (NUM_CH < 1 || NUM_CH > 8) begin : g_bad_num_ch
      $error("rcn_testmon: NUM_CH must be 1..8");
   end
   if (TIMEOUT_W < 1 || TIMEOUT == '0) begin : g_bad_timeout
      $error("rcn_testmon: TIMEOUT_W and TIMEOUT must be non-zero");
   end

   // Ring word fields: {valid, pending, wr, id[5:0], mask[3:0], addr[21:0], data[31:0]}
   logic        req_valid;
   logic        req_pend;
   logic        req_wr;
   logic [3:0]  req_mask;
   logic [21:0] req_addr;
   logic [31:0] req_data;
   logic [2:0]  req_ch;
   logic [1:0]  req_reg;
   logic        req_hit;

   assign req_valid = rcn_in[66];
   assign req_pend  = rcn_in[65];
   assign req_wr    = rcn_in[64];
   assign req_mask  = rcn_in[57:54];
   assign req_addr  = rcn_in[53:32];
   assign req_data  = rcn_in[31:0];
   assign req_ch    = req_addr[4:2];
   assign req_reg   = req_addr[1:0];
   assign req_hit   = req_valid && req_pend && (req_addr[21:5] == ADDR_BASE[21:5]);

   logic [NUM_CH-1:0] ch_sel;
   logic [NUM_CH-1:0] ch_done;
   logic [NUM_CH-1:0] tmo_flag;
   logic [31:0]       rd_data;

   logic [66:0] rcn_out_q, rcn_out_d;
   logic [31:0] prog_q [NUM_CH];
   logic [31:0] prog_d [NUM_CH];
   logic [31:0] fail_q [NUM_CH];
   logic [31:0] fail_d [NUM_CH];
   logic [31:0] pass_q [NUM_CH];
   logic [31:0] pass_d [NUM_CH];

   function automatic logic [31:0] lane_merge(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  m);
      logic [31:0] r;
      r = old_v;
      for (int unsigned k = 0; k < 4; k++) begin
         if (m[k]) r[8*k +: 8] = new_v[8*k +: 8];
      end
      return r;
   endfunction

   // Channel select for the current request and per-channel done flags
   always_comb begin
      ch_sel  = '0;
      ch_done = '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         ch_sel[i]  = req_hit && (req_ch == 3'(i));
         ch_done[i] = (fail_q[i] != '0) || (pass_q[i] != '0);
      end
   end

   // Read mux; a channel number beyond NUM_CH selects nothing and reads zero
   always_comb begin
      rd_data = '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         if (ch_sel[i]) begin
            case (req_reg)
               2'd0:    rd_data = prog_q[i];
               2'd1:    rd_data = fail_q[i];
               2'd2:    rd_data = pass_q[i];
               default: rd_data = {30'd0, tmo_flag[i], ch_done[i]};
            endcase
         end
      end
   end

   // Turn a matching request into its response; forward everything else
   always_comb begin
      rcn_out_d = rcn_in;
      if (req_hit) rcn_out_d = {1'b1, 1'b0, rcn_in[64:32], req_wr ? req_data : rd_data};
   end

   // Byte-lane register writes
   always_comb begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         prog_d[i] = prog_q[i];
         fail_d[i] = fail_q[i];
         pass_d[i] = pass_q[i];
         if (req_wr && ch_sel[i]) begin
            case (req_reg)
               2'd0:    prog_d[i] = lane_merge(prog_q[i], req_data, req_mask);
               2'd1:    fail_d[i] = lane_merge(fail_q[i], req_data, req_mask);
               2'd2:    pass_d[i] = lane_merge(pass_q[i], req_data, req_mask);
               default: ;
            endcase
         end
      end
   end

   // Ring output and test registers; reset also drops any request in flight
   always_ff @(posedge clk) begin
      if (rst) begin
         rcn_out_q <= '0;
         for (int unsigned i = 0; i < NUM_CH; i++) begin
            prog_q[i] <= '0;
            fail_q[i] <= '0;
            pass_q[i] <= '0;
         end
      end else begin
         rcn_out_q <= rcn_out_d;
         for (int unsigned i = 0; i < NUM_CH; i++) begin
            prog_q[i] <= prog_d[i];
            fail_q[i] <= fail_d[i];
            pass_q[i] <= pass_d[i];
         end
      end
   end

`ifdef RCN_TESTMON_WATCHDOG_EN
   localparam logic [TIMEOUT_W-1:0] LIMIT = TIMEOUT - TIMEOUT_W'(1);

   logic [TIMEOUT_W-1:0] cnt_q [NUM_CH];
   logic [TIMEOUT_W-1:0] cnt_d [NUM_CH];
   logic [NUM_CH-1:0]    tmo_q, tmo_d;

   // Watchdog: status clear wins, then a progress write, then normal counting;
   // on reaching the limit the flag sets and the counter holds
   always_comb begin
      tmo_d = tmo_q;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         cnt_d[i] = cnt_q[i];
         if (req_wr && ch_sel[i] && (req_reg == 2'd3) && req_mask[0] && req_data[1]) begin
            tmo_d[i] = 1'b0;
            cnt_d[i] = '0;
         end else if (req_wr && ch_sel[i] && (req_reg == 2'd0)) begin
            cnt_d[i] = '0;
         end else if (!ch_done[i] && !tmo_q[i]) begin
            if (cnt_q[i] == LIMIT) tmo_d[i] = 1'b1;
            else                   cnt_d[i] = cnt_q[i] + TIMEOUT_W'(1);
         end
      end
   end

   // Watchdog state
   always_ff @(posedge clk) begin
      if (rst) begin
         tmo_q <= '0;
         for (int unsigned i = 0; i < NUM_CH; i++) cnt_q[i] <= '0;
      end else begin
         tmo_q <= tmo_d;
         for (int unsigned i = 0; i < NUM_CH; i++) cnt_q[i] <= cnt_d[i];
      end
   end

   assign tmo_flag = tmo_q;
`else
   assign tmo_flag = '0;
`endif

   // Flatten per-channel registers onto the output buses
   always_comb begin
      test_progress = '0;
      test_fail     = '0;
      test_pass     = '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         test_progress[32*i +: 32] = prog_q[i];
         test_fail[32*i +: 32]     = fail_q[i];
         test_pass[32*i +: 32]     = pass_q[i];
      end
   end

   assign rcn_out      = rcn_out_q;
   assign test_timeout = tmo_flag;

endmodule

// File: tb/tb_rcn_testmon.sv
// tb_rcn_testmon: table-driven check of rcn_testmon (NUM_CH=4, TIMEOUT=16)
// with a response scoreboard and hand sequences for reset and watchdog timing.
module tb_rcn_testmon;

`ifdef RCN_TESTMON_WATCHDOG_EN
   localparam bit WD = 1'b1;
`else
   localparam bit WD = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst;
   logic [66:0]  rcn_in;
   logic [66:0]  rcn_out;
   logic [127:0] test_progress;
   logic [127:0] test_fail;
   logic [127:0] test_pass;
   logic [3:0]   test_timeout;

   rcn_testmon #(
      .ADDR_BASE (22'h3FFFE0),
      .NUM_CH    (4),
      .TIMEOUT_W (24),
      .TIMEOUT   (24'd16)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .rcn_in        (rcn_in),
      .rcn_out       (rcn_out),
      .test_progress (test_progress),
      .test_fail     (test_fail),
      .test_pass     (test_pass),
      .test_timeout  (test_timeout)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;
   logic [66:0] sb [$];

   typedef struct {
      string        name;
      logic [66:0]  din;
      logic [66:0]  dout;
      logic [127:0] prog;
      logic [127:0] fail;
      logic [127:0] pass;
   } vec_t;
   vec_t tbl [$];

   function automatic logic [66:0] mk(input logic v, input logic p, input logic w,
                                      input logic [5:0] id, input logic [3:0] m,
                                      input logic [21:0] a, input logic [31:0] d);
      return {v, p, w, id, m, a, d};
   endfunction

   task automatic add(input string nm, input logic [66:0] din, input logic [66:0] dout,
                      input logic [127:0] pr, input logic [127:0] fl, input logic [127:0] ps);
      vec_t v;
      v.name = nm; v.din = din; v.dout = dout; v.prog = pr; v.fail = fl; v.pass = ps;
      tbl.push_back(v);
   endtask

   task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, want %h", nm, act, exp);
      end
   endtask

   task automatic step(input logic [66:0] w, input logic [66:0] exp, input string nm);
      logic [66:0] e;
      rcn_in = w;
      sb.push_back(exp);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check(nm, 128'(rcn_out), 128'(e));
   endtask

   task automatic idle(input int unsigned n);
      for (int unsigned k = 0; k < n; k++) step('0, '0, "idle");
   endtask

   task automatic do_reset();
      rst = 1'b1;
      rcn_in = '0;
      sb.delete();
      repeat (2) @(posedge clk);
      #1;
      check("reset_out", 128'(rcn_out), 128'd0);
      check("reset_timeout", 128'(test_timeout), 128'd0);
      rst = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL sim_time_limit: got timeout, want $finish");
      $fatal(1, "simulation time limit reached");
   end

   initial begin
      logic [127:0] p1, p2, ps0, f3;
      p1  = {32'h0, 32'h0, 32'h0000_0005, 32'h0};
      p2  = {32'h0, 32'h00AB_0000, 32'h0000_0005, 32'h0};
      ps0 = {96'h0, 32'h0000_0001};
      f3  = {32'h1100_3300, 96'h0};

      add("wr_ch1_prog", mk(1,1,1,6'd1,4'hF,22'h3FFFE4,32'h0000_0005),
                         mk(1,0,1,6'd1,4'hF,22'h3FFFE4,32'h0000_0005), p1, '0, '0);
      add("wr_ch0_pass", mk(1,1,1,6'd2,4'h1,22'h3FFFE2,32'hAABB_CC01),
                         mk(1,0,1,6'd2,4'h1,22'h3FFFE2,32'hAABB_CC01), p1, '0, ps0);
      add("rd_ch0_stat", mk(1,1,0,6'd3,4'hF,22'h3FFFE3,32'hDEAD_BEEF),
                         mk(1,0,0,6'd3,4'hF,22'h3FFFE3,32'h0000_0001), p1, '0, ps0);
      add("rd_ch1_prog", mk(1,1,0,6'd4,4'h0,22'h3FFFE4,32'h0),
                         mk(1,0,0,6'd4,4'h0,22'h3FFFE4,32'h0000_0005), p1, '0, ps0);
      add("fwd_nomatch", mk(1,1,1,6'd5,4'hF,22'h000010,32'h1234_5678),
                         mk(1,1,1,6'd5,4'hF,22'h000010,32'h1234_5678), p1, '0, ps0);
      add("fwd_resp",    mk(1,0,0,6'd6,4'hF,22'h3FFFE0,32'hCAFE_F00D),
                         mk(1,0,0,6'd6,4'hF,22'h3FFFE0,32'hCAFE_F00D), p1, '0, ps0);
      add("rd_ch5_prog", mk(1,1,0,6'd7,4'hF,22'h3FFFF4,32'hFFFF_FFFF),
                         mk(1,0,0,6'd7,4'hF,22'h3FFFF4,32'h0), p1, '0, ps0);
      add("wr_ch5_prog", mk(1,1,1,6'd8,4'hF,22'h3FFFF4,32'hFFFF_FFFF),
                         mk(1,0,1,6'd8,4'hF,22'h3FFFF4,32'hFFFF_FFFF), p1, '0, ps0);
      add("wr_ch3_fail", mk(1,1,1,6'd9,4'hA,22'h3FFFED,32'h1122_3344),
                         mk(1,0,1,6'd9,4'hA,22'h3FFFED,32'h1122_3344), p1, f3, ps0);
      add("rd_ch3_fail", mk(1,1,0,6'd10,4'hF,22'h3FFFED,32'h0),
                         mk(1,0,0,6'd10,4'hF,22'h3FFFED,32'h1100_3300), p1, f3, ps0);
      add("fwd_idle",    '0, '0, p1, f3, ps0);
      add("wr_ch2_prog", mk(1,1,1,6'd12,4'h4,22'h3FFFE8,32'h12AB_3456),
                         mk(1,0,1,6'd12,4'h4,22'h3FFFE8,32'h12AB_3456), p2, f3, ps0);
      add("rd_ch1_pass", mk(1,1,0,6'd13,4'hF,22'h3FFFE6,32'h0),
                         mk(1,0,0,6'd13,4'hF,22'h3FFFE6,32'h0), p2, f3, ps0);
      add("fwd_invalid", mk(0,1,0,6'd14,4'hF,22'h3FFFE4,32'h5555_5555),
                         mk(0,1,0,6'd14,4'hF,22'h3FFFE4,32'h5555_5555), p2, f3, ps0);
      add("fwd_adjacent",mk(1,1,0,6'd15,4'hF,22'h3FFFC4,32'h0),
                         mk(1,1,0,6'd15,4'hF,22'h3FFFC4,32'h0), p2, f3, ps0);
      add("rd_ch3_stat", mk(1,1,0,6'd16,4'hF,22'h3FFFEF,32'h0),
                         mk(1,0,0,6'd16,4'hF,22'h3FFFEF,32'h0000_0001), p2, f3, ps0);

      // Reset state, with a request presented while reset is held
      rst = 1'b1;
      rcn_in = mk(1,1,1,6'd0,4'hF,22'h3FFFE0,32'hFFFF_FFFF);
      repeat (3) @(posedge clk);
      #1;
      check("init_out", 128'(rcn_out), 128'd0);
      check("init_prog", test_progress, 128'd0);
      check("init_fail", test_fail, 128'd0);
      check("init_pass", test_pass, 128'd0);
      check("init_timeout", 128'(test_timeout), 128'd0);
      rst = 1'b0;

      foreach (tbl[i]) begin
         step(tbl[i].din, tbl[i].dout, tbl[i].name);
         check({tbl[i].name, "/prog"}, test_progress, tbl[i].prog);
         check({tbl[i].name, "/fail"}, test_fail, tbl[i].fail);
         check({tbl[i].name, "/pass"}, test_pass, tbl[i].pass);
      end

      // Reset with a request in flight: no response, registers cleared
      rst = 1'b1;
      sb.delete();
      rcn_in = mk(1,1,0,6'h21,4'hF,22'h3FFFE4,32'h0);
      @(posedge clk);
      #1;
      check("rst_inflight_out", 128'(rcn_out), 128'd0);
      check("rst_prog_clear", test_progress, 128'd0);
      check("rst_fail_clear", test_fail, 128'd0);
      check("rst_pass_clear", test_pass, 128'd0);
      rcn_in = mk(1,1,1,6'd22,4'hF,22'h3FFFE0,32'h0000_00FF);
      @(posedge clk);
      #1;
      check("rst_write_out", 128'(rcn_out), 128'd0);
      check("rst_write_ignored", test_progress, 128'd0);
      rst = 1'b0;
      step(mk(1,1,1,6'd23,4'hF,22'h3FFFE0,32'h0000_0007),
           mk(1,0,1,6'd23,4'hF,22'h3FFFE0,32'h0000_0007), "first_after_rst");
      check("first_after_rst/prog", test_progress, {96'h0, 32'h0000_0007});

      // Watchdog expiry, status read and status clear
      do_reset();
      idle(15);
      check("to_before_limit", 128'(test_timeout), 128'd0);
      idle(1);
      check("to_expired", 128'(test_timeout), 128'(WD ? 4'hF : 4'h0));
      step(mk(1,1,0,6'd30,4'hF,22'h3FFFEB,32'h0),
           mk(1,0,0,6'd30,4'hF,22'h3FFFEB,WD ? 32'h2 : 32'h0), "rd_ch2_stat_to");
      step(mk(1,1,1,6'd31,4'h1,22'h3FFFEB,32'h0000_0002),
           mk(1,0,1,6'd31,4'h1,22'h3FFFEB,32'h0000_0002), "wr_ch2_stat_clr");
      check("to_ch2_cleared", 128'(test_timeout), 128'(WD ? 4'hB : 4'h0));
      step(mk(1,1,0,6'd32,4'hF,22'h3FFFEB,32'h0),
           mk(1,0,0,6'd32,4'hF,22'h3FFFEB,32'h0), "rd_ch2_stat_clr");

      // Progress write in the expiry cycle wins and restarts the counter
      do_reset();
      idle(15);
      step(mk(1,1,1,6'd40,4'hF,22'h3FFFE0,32'h0),
           mk(1,0,1,6'd40,4'hF,22'h3FFFE0,32'h0), "prog_at_expiry");
      check("to_prio_write", 128'(test_timeout), 128'(WD ? 4'hE : 4'h0));
      idle(15);
      check("to_restart_hold", 128'(test_timeout), 128'(WD ? 4'hE : 4'h0));
      idle(1);
      check("to_restart_expire", 128'(test_timeout), 128'(WD ? 4'hF : 4'h0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
